// File: rtl/mem_pkg.sv
// Shared types and constants for the word-wide memory responder and its byte-lane bank.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  // Element 0 is the lane holding the byte at the lowest address of the word.
  typedef logic [0:WORD_BYTES-1][7:0] byte_word_t;

  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic en,
                                                      input logic [WORD_BYTES-1:0] be);
    return en ? be : '0;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Four independent 8-bit lane arrays with per-lane write enables and a registered read port
// whose output register doubles as the responder's read-data holding register.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  input  logic [WORD_BYTES-1:0] wr_en_i,
  input  logic [AW-1:0]         addr_i,
  input  byte_word_t            wdata_i,
  output byte_word_t            rdata_o
);

  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    logic [7:0] laneMem [DEPTH_WORDS];
    logic [7:0] rdLane_q;

    // Storage is deliberately left unreset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
      if (wr_en_i[g]) begin
        laneMem[addr_i] <= wdata_i[g];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rdLane_q <= '0;
      end else if (rd_clr_i) begin
        rdLane_q <= '0;
      end else if (rd_en_i) begin
        rdLane_q <= laneMem[addr_i];
      end
    end

    assign rdata_o[g] = rdLane_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding-request data-memory responder with a fixed access latency,
// byte-masked writes and an error flag for word indices beyond the array.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_write_en,
  input  logic [WORD_BYTES-1:0] mem_byte_en,
  input  byte_word_t            mem_data_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output byte_word_t            mem_data_out,
  output logic                  resp_err
);

  localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);

  mem_state_t            state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [29:0]           wordIdx_q, wordIdx_d;
  logic                  writeEn_q, writeEn_d;
  logic [WORD_BYTES-1:0] byteEn_q, byteEn_d;
  byte_word_t            wrData_q, wrData_d;
  logic                  err_q, err_d;
  logic                  access;
  logic                  inRange;
  logic [1:0]            addrLsb_unused;

  assign addrLsb_unused = mem_addr[1:0];
  assign inRange        = (wordIdx_q < DEPTH_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wordIdx_q <= '0;
      writeEn_q <= 1'b0;
      byteEn_q  <= '0;
      wrData_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wordIdx_q <= wordIdx_d;
      writeEn_q <= writeEn_d;
      byteEn_q  <= byteEn_d;
      wrData_q  <= wrData_d;
      err_q     <= err_d;
    end
  end

  // Request fields are captured only on acceptance; everything after uses the latched copy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wordIdx_d = wordIdx_q;
    writeEn_d = writeEn_q;
    byteEn_d  = byteEn_q;
    wrData_d  = wrData_q;
    err_d     = err_q;
    access    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wordIdx_d = mem_addr[31:2];
          writeEn_d = mem_write_en;
          byteEn_d  = mem_byte_en;
          wrData_d  = mem_data_in;
          cnt_d     = LAT_INIT;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          err_d   = ~inRange;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;

  // Out-of-range reads zero the output register; out-of-range writes never reach the lanes.
  mem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk_i    (clk),
    .rst_i    (rst),
    .rd_en_i  (access & ~writeEn_q & inRange),
    .rd_clr_i (access & ~writeEn_q & ~inRange),
    .wr_en_i  (lane_mask(access & writeEn_q & inRange, byteEn_q)),
    .addr_i   (wordIdx_q[AW-1:0]),
    .wdata_i  (wrData_q),
    .rdata_o  (mem_data_out)
  );

endmodule
